// File: rtl/exception_pkg.sv
// ----------------------------------------------------------------------------
// exception_pkg
// Shared types and constants for the exception sequencer: the FSM state
// encoding, exception cause codes, datapath mux select values, the reserved
// handler-vector addresses, a priority encoder for simultaneous requests and
// the Moore output decoder used by the sequencer.
// ----------------------------------------------------------------------------
package exception_pkg;

  // Sequencer states; any encoding outside this list is treated as IDLE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EPC  = 3'd1,
    ST_ADDR = 3'd2,
    ST_WAIT = 3'd3,
    ST_MDR  = 3'd4,
    ST_PCW  = 3'd5
  } excState_t;

  // Exception causes; the value doubles as the exception-address mux select.
  localparam logic [1:0] CAUSE_OPCODE = 2'b00;
  localparam logic [1:0] CAUSE_OVF    = 2'b01;
  localparam logic [1:0] CAUSE_DIV0   = 2'b10;

  // Datapath mux select values driven while the sequencer owns the datapath.
  localparam logic [1:0] IORD_EXCP = 2'b10;
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [1:0] LS_BYTE   = 2'b10;
  localparam logic [2:0] PCSRC_LS  = 3'b100;

  // Reserved memory bytes holding the handler address for each cause.
  localparam logic [7:0] VEC_OPCODE = 8'd253;
  localparam logic [7:0] VEC_OVF    = 8'd254;
  localparam logic [7:0] VEC_DIV0   = 8'd255;

  // Registered control bundle presented to the datapath.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] cause;
    logic [1:0] excpControl;
    logic [1:0] iord;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluControl;
    logic       epcControl;
    logic       mdrWrite;
    logic [1:0] lsControl;
    logic [2:0] pcSource;
    logic       pcWrite;
  } ctrl_t;

  // Fixed priority opcode > overflow > div0. Only meaningful when at least
  // one request is high; the caller qualifies it with an any-request term.
  function automatic logic [1:0] encodeCause(input logic opReq,
                                             input logic ovfReq,
                                             input logic div0Req);
    logic [1:0] c;
    c = CAUSE_DIV0;
    if (ovfReq) c = CAUSE_OVF;
    if (opReq)  c = CAUSE_OPCODE;
    if (!(opReq || ovfReq || div0Req)) c = CAUSE_OPCODE;
    return c;
  endfunction

  // Handler vector address selected by a cause, as the address mux sees it.
  function automatic logic [7:0] vectorAddress(input logic [1:0] c);
    logic [7:0] addr;
    case (c)
      CAUSE_OVF:  addr = VEC_OVF;
      CAUSE_DIV0: addr = VEC_DIV0;
      default:    addr = VEC_OPCODE;
    endcase
    return addr;
  endfunction

  // Moore decode of the control bundle for a given state and latched cause.
  // IDLE and every illegal encoding produce an all-zero bundle.
  function automatic ctrl_t decodeState(input excState_t s,
                                        input logic [1:0] c);
    ctrl_t o;
    o = '0;
    case (s)
      ST_EPC: begin
        o.busy       = 1'b1;
        o.cause      = c;
        o.aluSrcA    = SRCA_PC;
        o.aluSrcB    = SRCB_FOUR;
        o.aluControl = ALU_SUB;
        o.epcControl = 1'b1;
      end
      ST_ADDR, ST_WAIT: begin
        o.busy        = 1'b1;
        o.cause       = c;
        o.iord        = IORD_EXCP;
        o.excpControl = c;
      end
      ST_MDR: begin
        o.busy        = 1'b1;
        o.cause       = c;
        o.iord        = IORD_EXCP;
        o.excpControl = c;
        o.mdrWrite    = 1'b1;
      end
      ST_PCW: begin
        o.busy      = 1'b1;
        o.done      = 1'b1;
        o.cause     = c;
        o.lsControl = LS_BYTE;
        o.pcSource  = PCSRC_LS;
        o.pcWrite   = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/exception_sequencer.sv
// ----------------------------------------------------------------------------
// exception_sequencer
// Multicycle sequencer that takes over the datapath when an exception is
// raised (invalid opcode, ALU overflow, divide-by-zero). It writes PC-4 into
// EPC, reads the handler byte from reserved address 253/254/255 and loads it,
// zero-extended, into PC. The main control FSM freezes while busy is high.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   opcode_req, ovf_req,  exception requests, sampled only in IDLE
//   div0_req
//   busy                  sequencer owns the datapath
//   ack                   request accepted this cycle (combinational)
//   done                  PC-write cycle
//   cause                 latched cause, zero while idle
//   excp_control, iord,   datapath mux selects and write enables
//   alu_src_a, alu_src_b,
//   alu_control,
//   epc_control,
//   mem_write, mdr_write,
//   ls_control,
//   pc_source, pc_write
// ----------------------------------------------------------------------------
module exception_sequencer
  import exception_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       opcode_req,
  input  logic       ovf_req,
  input  logic       div0_req,
  output logic       busy,
  output logic       ack,
  output logic       done,
  output logic [1:0] cause,
  output logic [1:0] excp_control,
  output logic [1:0] iord,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       epc_control,
  output logic       mem_write,
  output logic       mdr_write,
  output logic [1:0] ls_control,
  output logic [2:0] pc_source,
  output logic       pc_write
);

  // Counter preload: WAIT lasts MEM_WAIT cycles, leaving on a zero count.
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  excState_t  state;
  excState_t  nextState;
  logic [1:0] causeReg;
  logic [1:0] nextCause;
  logic [2:0] waitCnt;
  logic [2:0] nextWait;
  ctrl_t      ctrlReg;
  logic       anyReq;
  logic [1:0] reqCause;

  assign anyReq   = opcode_req || ovf_req || div0_req;
  assign reqCause = encodeCause(opcode_req, ovf_req, div0_req);

  // Acceptance is visible in the same IDLE cycle the request is seen, so
  // the requester can drop its line right after the handshake.
  assign ack = (state == ST_IDLE) && anyReq;

  // Next-state, next-cause and wait-counter logic. Requests are only looked
  // at in IDLE, so anything raised mid-sequence is ignored unless it is
  // still held once the sequencer comes back to IDLE. Illegal encodings
  // fall back to IDLE.
  always_comb begin
    nextState = state;
    nextCause = causeReg;
    nextWait  = waitCnt;
    case (state)
      ST_IDLE: begin
        if (anyReq) begin
          nextState = ST_EPC;
          nextCause = reqCause;
        end
      end
      ST_EPC:  nextState = ST_ADDR;
      ST_ADDR: begin
        nextState = ST_WAIT;
        nextWait  = WAIT_INIT;
      end
      ST_WAIT: begin
        if (waitCnt == 3'd0) begin
          nextState = ST_MDR;
        end else begin
          nextWait = waitCnt - 3'd1;
        end
      end
      ST_MDR:  nextState = ST_PCW;
      ST_PCW:  nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // State register plus registered Moore outputs. The output bundle is
  // decoded from the state being entered, so it always matches the state
  // register without a combinational decode on the outputs. Reset drops
  // everything to zero on the same edge, so an interrupted sequence never
  // completes its EPC, MDR or PC write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      causeReg <= CAUSE_OPCODE;
      waitCnt  <= 3'd0;
      ctrlReg  <= '0;
    end else begin
      state    <= nextState;
      causeReg <= nextCause;
      waitCnt  <= nextWait;
      ctrlReg  <= decodeState(nextState, nextCause);
    end
  end

  assign busy         = ctrlReg.busy;
  assign done         = ctrlReg.done;
  assign cause        = ctrlReg.cause;
  assign excp_control = ctrlReg.excpControl;
  assign iord         = ctrlReg.iord;
  assign alu_src_a    = ctrlReg.aluSrcA;
  assign alu_src_b    = ctrlReg.aluSrcB;
  assign alu_control  = ctrlReg.aluControl;
  assign epc_control  = ctrlReg.epcControl;
  assign mdr_write    = ctrlReg.mdrWrite;
  assign ls_control   = ctrlReg.lsControl;
  assign pc_source    = ctrlReg.pcSource;
  assign pc_write     = ctrlReg.pcWrite;

  // Memory is only ever read during an exception sequence.
  assign mem_write = 1'b0;

endmodule

// File: tb/tb_exception_sequencer.sv
// ----------------------------------------------------------------------------
// tb_exception_sequencer
// Two sequencer instances (MEM_WAIT=1 and MEM_WAIT=3) driven by directed
// request patterns. Each accepted sequence has its expected cause pushed
// into a per-instance queue; a negedge monitor pops on ack and compares the
// whole output bundle every cycle against a hand-written cycle schedule.
// ----------------------------------------------------------------------------
module tb_exception_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic monitorOn = 1'b0;

  // Requests, packed as {opcode, overflow, div0} per instance.
  logic [2:0] reqA;
  logic [2:0] reqB;

  logic       busyA, ackA, doneA, epcA, memwA, mdrwA, pcwA;
  logic [1:0] causeA, excpA, iordA, srcAA, srcBA, lsA;
  logic [2:0] alucA, pcsA;
  logic       busyB, ackB, doneB, epcB, memwB, mdrwB, pcwB;
  logic [1:0] causeB, excpB, iordB, srcAB, srcBB, lsB;
  logic [2:0] alucB, pcsB;

  logic [23:0] bundleA;
  logic [23:0] bundleB;

  int checks = 0;
  int errors = 0;

  logic [1:0] expQA[$];
  logic [1:0] expQB[$];
  int         phase[2];
  logic [1:0] curCause[2];

  always #5 clk = ~clk;

  exception_sequencer #(.MEM_WAIT(1)) dutA (
    .clk(clk), .reset(reset),
    .opcode_req(reqA[2]), .ovf_req(reqA[1]), .div0_req(reqA[0]),
    .busy(busyA), .ack(ackA), .done(doneA), .cause(causeA),
    .excp_control(excpA), .iord(iordA), .alu_src_a(srcAA),
    .alu_src_b(srcBA), .alu_control(alucA), .epc_control(epcA),
    .mem_write(memwA), .mdr_write(mdrwA), .ls_control(lsA),
    .pc_source(pcsA), .pc_write(pcwA)
  );

  exception_sequencer #(.MEM_WAIT(3)) dutB (
    .clk(clk), .reset(reset),
    .opcode_req(reqB[2]), .ovf_req(reqB[1]), .div0_req(reqB[0]),
    .busy(busyB), .ack(ackB), .done(doneB), .cause(causeB),
    .excp_control(excpB), .iord(iordB), .alu_src_a(srcAB),
    .alu_src_b(srcBB), .alu_control(alucB), .epc_control(epcB),
    .mem_write(memwB), .mdr_write(mdrwB), .ls_control(lsB),
    .pc_source(pcsB), .pc_write(pcwB)
  );

  assign bundleA = {busyA, doneA, causeA, excpA, iordA, srcAA, srcBA, alucA,
                    epcA, memwA, mdrwA, lsA, pcsA, pcwA};
  assign bundleB = {busyB, doneB, causeB, excpB, iordB, srcAB, srcBB, alucB,
                    epcB, memwB, mdrwB, lsB, pcsB, pcwB};

  // Expected output bundle k cycles after acceptance (k=1 is the EPC cycle).
  function automatic logic [23:0] buildExpected(input int k, input int mw,
                                                input logic [1:0] c);
    logic       busyE, doneE, epcE, mdrE, pcwE;
    logic [1:0] causeE, excpE, iordE, srcAE, srcBE, lsE;
    logic [2:0] aluE, pcsE;
    busyE = 1'b1; doneE = 1'b0; epcE = 1'b0; mdrE = 1'b0; pcwE = 1'b0;
    causeE = c; excpE = 2'b00; iordE = 2'b00; srcAE = 2'b00; srcBE = 2'b00;
    lsE = 2'b00; aluE = 3'b000; pcsE = 3'b000;
    if (k == 1) begin
      srcAE = 2'b00; srcBE = 2'b01; aluE = 3'b010; epcE = 1'b1;
    end else if (k >= 2 && k <= 2 + mw) begin
      iordE = 2'b10; excpE = c;
    end else if (k == 3 + mw) begin
      iordE = 2'b10; excpE = c; mdrE = 1'b1;
    end else if (k == 4 + mw) begin
      doneE = 1'b1; lsE = 2'b10; pcsE = 3'b100; pcwE = 1'b1;
    end
    return {busyE, doneE, causeE, excpE, iordE, srcAE, srcBE, aluE,
            epcE, 1'b0, mdrE, lsE, pcsE, pcwE};
  endfunction

  // Compare one instance's outputs for this cycle, then advance its model.
  task automatic checkOutput(input int id, input int mw,
                             input logic [23:0] act, input logic actAck,
                             input logic anyReq, input logic rstNow);
    logic [23:0] expV;
    logic        expAck;
    int          qSize;
    if (phase[id] == 0) begin
      expV   = '0;
      expAck = anyReq;
    end else begin
      expV   = buildExpected(phase[id], mw, curCause[id]);
      expAck = 1'b0;
    end
    checks++;
    if (act !== expV || actAck !== expAck) begin
      errors++;
      $display("[TB] FAIL dut%0d phase%0d outputs: got %h ack %b, expected %h ack %b at %0t",
               id, phase[id], act, actAck, expV, expAck, $time);
    end
    if (rstNow) begin
      phase[id] = 0;
    end else if (phase[id] == 0) begin
      if (anyReq) begin
        qSize = (id == 0) ? expQA.size() : expQB.size();
        checks++;
        if (qSize == 0) begin
          errors++;
          $display("[TB] FAIL dut%0d unexpected ack: got ack with no queued request, expected none at %0t",
                   id, $time);
          curCause[id] = 2'b11;
        end else if (id == 0) begin
          curCause[id] = expQA.pop_front();
        end else begin
          curCause[id] = expQB.pop_front();
        end
        phase[id] = 1;
      end
    end else if (phase[id] == 4 + mw) begin
      phase[id] = 0;
    end else begin
      phase[id] = phase[id] + 1;
    end
  endtask

  // Monitor: sample half a cycle after each active edge.
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput(0, 1, bundleA, ackA, |reqA, reset);
      checkOutput(1, 3, bundleB, ackB, |reqB, reset);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExpected(input int id, input logic [1:0] c);
    if (id == 0) expQA.push_back(c);
    else         expQB.push_back(c);
  endtask

  // Raise the given requests for holdCycles cycles, then drop them.
  task automatic applyStimulus(input int id, input logic [2:0] reqs,
                               input int holdCycles);
    if (id == 0) reqA = reqs;
    else         reqB = reqs;
    idle(holdCycles);
    if (id == 0) reqA = 3'b000;
    else         reqB = 3'b000;
  endtask

  initial begin
    @(posedge clk);
    monitorOn = 1'b1;
  end

  initial begin
    phase[0] = 0; phase[1] = 0;
    curCause[0] = 2'b00; curCause[1] = 2'b00;
    reset = 1'b1;
    reqA  = 3'b000;
    reqB  = 3'b000;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Single-cycle overflow pulse.
    pushExpected(0, 2'b01);
    applyStimulus(0, 3'b010, 1);
    idle(8);

    // All three at once: opcode wins, the others are dropped.
    pushExpected(0, 2'b00);
    applyStimulus(0, 3'b111, 1);
    idle(8);

    // div0 raised during WAIT and dropped before done: ignored.
    pushExpected(0, 2'b01);
    applyStimulus(0, 3'b010, 1);
    idle(2);
    applyStimulus(0, 3'b001, 1);
    idle(4);
    pushExpected(0, 2'b10);
    applyStimulus(0, 3'b001, 1);
    idle(8);

    // Reset in the MDR cycle aborts the sequence.
    pushExpected(0, 2'b01);
    applyStimulus(0, 3'b010, 1);
    idle(3);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(4);

    // Overflow held 12 cycles: two back-to-back sequences.
    pushExpected(0, 2'b01);
    pushExpected(0, 2'b01);
    applyStimulus(0, 3'b010, 12);
    idle(6);

    // Longer memory wait on the second instance.
    pushExpected(1, 2'b01);
    applyStimulus(1, 3'b010, 1);
    idle(10);
    pushExpected(1, 2'b10);
    applyStimulus(1, 3'b001, 1);
    idle(10);

    checks++;
    if (expQA.size() != 0) begin
      errors++;
      $display("[TB] FAIL dut0 queue drain: got %0d unserviced, expected 0", expQA.size());
    end
    checks++;
    if (expQB.size() != 0) begin
      errors++;
      $display("[TB] FAIL dut1 queue drain: got %0d unserviced, expected 0", expQB.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
Multicycle sequencer that takes over the MIPS datapath when an exception is raised: invalid opcode, ALU overflow or divide-by-zero. It saves PC-4 into EPC, reads the handler byte from reserved memory address 253, 254 or 255, and loads that byte, zero-extended, into PC. It sits beside the main control FSM, which freezes while busy=1. A top-level mux selects this block's datapath selects over the main FSM's while busy=1.

Parameters:
MEM_WAIT, 1, number of wait cycles between presenting the exception address and latching memory data into MDR (range 1..7).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
opcode_req  input  1  invalid-opcode exception request (level, sampled in IDLE)
ovf_req  input  1  ALU overflow exception request (the ALU O flag qualified by main control)
div0_req  input  1  divide-by-zero request from the divider
busy  output  1  high from the cycle after acceptance through the final cycle
ack  output  1  one-cycle pulse in the cycle a request is accepted
done  output  1  one-cycle pulse in the PC-write cycle
cause  output  2  latched cause: 00 opcode, 01 overflow, 10 div0
excp_control  output  2  select for the exception-address mux (00→253, 01→254, 10→255)
iord  output  2  memory address mux select; 10 = exception address
alu_src_a  output  2  00 = PC
alu_src_b  output  2  01 = constant 4
alu_control  output  3  010 = subtract
epc_control  output  1  EPC write enable
mem_write  output  1  held 0 by this block
mdr_write  output  1  memory data register write enable
ls_control  output  2  load-size select; 10 = byte, zero-extended
pc_source  output  3  PC mux select; 100 = load-size unit output
pc_write  output  1  PC write enable

Behaviour:
- FSM states: IDLE, EPC, ADDR, WAIT, MDR, PCW. Outputs are Moore-decoded from the state register, except ack, which is decoded from IDLE and the requests.
- Reset (synchronous): state=IDLE, cause=00, wait counter=0.
- Every output is 0 in IDLE and after reset. Exception: ack may be 1 in IDLE when a request is present.
- IDLE: if any request is high, then ack=1, cause is latched, and the next state is EPC. Otherwise remain in IDLE.
- Priority when requests are simultaneous: opcode > overflow > div0. Lower-priority simultaneous requests are dropped; they are not queued.
- EPC: alu_src_a=00, alu_src_b=01, alu_control=010, epc_control=1. EPC captures PC-4. Next state is ADDR.
- ADDR: iord=10, excp_control=cause. The wait counter loads MEM_WAIT-1. Next state is WAIT.
- WAIT: iord and excp_control are held. The counter decrements. When the counter reaches 0, the next state is MDR.
- MDR: iord and excp_control are held, mdr_write=1. Next state is PCW.
- PCW: ls_control=10, pc_source=100, pc_write=1, done=1. Next state is IDLE.
- busy=1 in every state except IDLE. Total latency from acceptance to done is 4+MEM_WAIT cycles (5 for MEM_WAIT=1).
- Requests arriving while busy=1 are ignored. The requester must still be asserting in the IDLE cycle after done for the request to be taken.
- A request held high continuously re-triggers on the IDLE cycle immediately after PCW. Back-to-back sequences are legal.
- Reset during any state forces IDLE on the next edge. No partial write completes after the reset edge. The cause and counter are cleared.
- mem_write is never asserted by this block.
- Cause encoding 11 is unreachable; if the state register is corrupted, illegal states decode to IDLE.

Decomposition:
- Shared package exception_pkg holds:
  - state enum
  - cause codes
  - mux select constants: IORD_EXCP=2'b10, SRCA_PC=2'b00, SRCB_FOUR=2'b01, ALU_SUB=3'b010, LS_BYTE=2'b10, PCSRC_LS=3'b100
  - exception vector addresses 253/254/255
- No sub-module is needed. The wait counter is a few lines inside the FSM. A priority encoder function may live in the package.

Test Plan:
- ovf_req pulse for 1 cycle in IDLE, MEM_WAIT=1 → ack at T0. epc_control at T1 with alu_control=010. iord=10 and excp_control=01 at T2–T4. mdr_write at T4. pc_write, pc_source=100, ls_control=10 and done at T5. busy high over T1–T5.
- opcode_req, ovf_req and div0_req high together → cause=00, excp_control=00 (address 253). Overflow and div0 are not serviced afterwards once deasserted.
- div0_req asserted during WAIT of an ongoing overflow sequence, then dropped before done → no second sequence. Assert it again in IDLE → cause=10 and excp_control=10.
- MEM_WAIT=3 → ADDR+WAIT span 4 cycles with iord held at 10. done arrives 7 cycles after ack.
- reset asserted in the MDR state → next cycle state=IDLE, all outputs 0, cause=00. No pc_write occurs.
- ovf_req held high for 12 cycles → two complete back-to-back sequences. The second ack falls exactly one cycle after the first done.
